// File: rtl/cameralink_base_video_stream_rx_if.sv
// AXI4-Stream video beat bundle: 24-bit pixel, tuser = start of frame,
// tlast = end of line. master drives data/valid, slave drives ready.
interface cameralink_base_video_stream_rx_if;
   logic [23:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tuser;
   logic        tlast;

   modport master (
      output tdata,
      output tvalid,
      output tuser,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tuser,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/cameralink_base_video_stream_rx.sv
// Camera Link base (chip X) to AXI4-Stream video receiver.
// Ports: clk/rst, lval/fval/dval + port_a/b/c in, m_axis (master) out,
//        line_width/frame_height/meas_valid measurement, sticky overflow
//        with overflow_clr, frame_active status.
module cameralink_base_video_stream_rx #(
   parameter int FIFO_DEPTH = 16,
   parameter bit USE_DVAL   = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lval,
   input  logic                 fval,
   input  logic                 dval,
   input  logic [7:0]           port_a,
   input  logic [7:0]           port_b,
   input  logic [7:0]           port_c,
   cameralink_base_video_stream_rx_if.master m_axis,
   output logic [CNT_W-1:0]     line_width,
   output logic [CNT_W-1:0]     frame_height,
   output logic                 meas_valid,
   output logic                 overflow,
   input  logic                 overflow_clr,
   output logic                 frame_active
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      ACTIVE,
      DISCARD
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // input register stage
   logic        lval_q;
   logic        fval_q;
   logic        dval_q;
   logic [23:0] pix_q;

   // fval resets high so IDLE only leaves after a real fval=0 from the
   // camera; otherwise a frame running at reset release would be taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         lval_q <= 1'b0;
         fval_q <= 1'b1;
         dval_q <= 1'b0;
         pix_q  <= '0;
      end else begin
         lval_q <= lval;
         fval_q <= fval;
         dval_q <= dval;
         pix_q  <= {port_c, port_b, port_a};
      end
   end

   state_t           state_q, state_d;
   logic             hold_vld_q, hold_vld_d;
   logic [23:0]      hold_data_q, hold_data_d;
   logic             sof_q, sof_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0] line_width_q, line_width_d;
   logic [CNT_W-1:0] frame_height_q, frame_height_d;
   logic             meas_valid_q, meas_valid_d;
   logic             ovf_q, ovf_d;

   logic [25:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;

   logic pix_ok;
   logic line_off;
   logic wr_en;
   logic wr_last;
   logic drop;
   logic wr_ok;
   logic rd;
   logic full;
   logic out_vld;

   assign out_vld  = (cnt_q != '0);
   assign full     = (cnt_q == FULL_CNT);
   assign rd       = out_vld & m_axis.tready;
   assign pix_ok   = fval_q & lval_q & (dval_q | ~USE_DVAL);
   assign line_off = ~lval_q | ~fval_q;

   always_comb begin
      state_d        = state_q;
      hold_vld_d     = hold_vld_q;
      hold_data_d    = hold_data_q;
      sof_d          = sof_q;
      pix_cnt_d      = pix_cnt_q;
      line_cnt_d     = line_cnt_q;
      line_width_d   = line_width_q;
      frame_height_d = frame_height_q;
      meas_valid_d   = 1'b0;
      wr_en          = 1'b0;
      wr_last        = 1'b0;
      drop           = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!fval_q) state_d = WAIT_SOF;
         end
         WAIT_SOF: begin
            if (fval_q) begin
               state_d    = ACTIVE;
               sof_d      = 1'b1;
               pix_cnt_d  = '0;
               line_cnt_d = '0;
            end
         end
         ACTIVE: begin
            // the held pixel is only known to be mid-line once the next
            // pixel arrives, and end-of-line once lval/fval drop
            if (pix_ok) begin
               hold_vld_d  = 1'b1;
               hold_data_d = pix_q;
               wr_en       = hold_vld_q;
               pix_cnt_d   = sat_inc(pix_cnt_q);
            end else if (hold_vld_q && line_off) begin
               wr_en      = 1'b1;
               wr_last    = 1'b1;
               hold_vld_d = 1'b0;
            end

            if (line_off && pix_cnt_q != '0) begin
               line_width_d = pix_cnt_q;
               line_cnt_d   = sat_inc(line_cnt_q);
               pix_cnt_d    = '0;
            end

            if (!fval_q) begin
               state_d        = WAIT_SOF;
               frame_height_d = line_cnt_d;
               meas_valid_d   = 1'b1;
               line_cnt_d     = '0;
            end

            drop = wr_en & full & ~rd;
            if (drop) begin
               state_d        = DISCARD;
               hold_vld_d     = 1'b0;
               frame_height_d = frame_height_q;
               meas_valid_d   = 1'b0;
            end else if (wr_en) begin
               sof_d = 1'b0;
            end
         end
         DISCARD: begin
            if (!fval_q) state_d = WAIT_SOF;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ovf_d = drop | (ovf_q & ~overflow_clr);
   assign wr_ok = wr_en & ~drop;

   always_comb begin
      wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      unique case ({wr_ok, rd})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         hold_vld_q     <= 1'b0;
         hold_data_q    <= '0;
         sof_q          <= 1'b0;
         pix_cnt_q      <= '0;
         line_cnt_q     <= '0;
         line_width_q   <= '0;
         frame_height_q <= '0;
         meas_valid_q   <= 1'b0;
         ovf_q          <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         hold_vld_q     <= hold_vld_d;
         hold_data_q    <= hold_data_d;
         sof_q          <= sof_d;
         pix_cnt_q      <= pix_cnt_d;
         line_cnt_q     <= line_cnt_d;
         line_width_q   <= line_width_d;
         frame_height_q <= frame_height_d;
         meas_valid_q   <= meas_valid_d;
         ovf_q          <= ovf_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         cnt_q          <= cnt_d;
      end
   end

   // storage needs no reset: cnt_q gates every read
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= {sof_q, wr_last, hold_data_q};
   end

   logic [25:0] head;
   assign head = out_vld ? mem_q[rd_ptr_q] : '0;

   assign m_axis.tvalid = out_vld;
   assign m_axis.tuser  = head[25];
   assign m_axis.tlast  = head[24];
   assign m_axis.tdata  = head[23:0];

   assign line_width   = line_width_q;
   assign frame_height = frame_height_q;
   assign meas_valid   = meas_valid_q;
   assign overflow     = ovf_q;
   assign frame_active = (state_q == ACTIVE);

endmodule

// File: tb/tb_cameralink_base_video_stream_rx.sv
// Directed bench for cameralink_base_video_stream_rx: three instances
// (default, USE_DVAL=1, FIFO_DEPTH=4) share the camera inputs and tready.
`timescale 1ns/1ps
module tb_cameralink_base_video_stream_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       lval = 1'b0;
   logic       fval = 1'b0;
   logic       dval = 1'b0;
   logic [7:0] pa = '0;
   logic [7:0] pb = '0;
   logic [7:0] pc = '0;
   logic       tready = 1'b1;
   logic       ovf_clr = 1'b0;

   cameralink_base_video_stream_rx_if ax0 ();
   cameralink_base_video_stream_rx_if ax1 ();
   cameralink_base_video_stream_rx_if ax2 ();
   assign ax0.tready = tready;
   assign ax1.tready = tready;
   assign ax2.tready = tready;

   logic [15:0] lw0, lw1, lw2, fh0, fh1, fh2;
   logic        mv0, mv1, mv2, ov0, ov1, ov2, fa0, fa1, fa2;

   cameralink_base_video_stream_rx u0 (
      .clk(clk), .rst(rst), .lval(lval), .fval(fval), .dval(dval),
      .port_a(pa), .port_b(pb), .port_c(pc), .m_axis(ax0),
      .line_width(lw0), .frame_height(fh0), .meas_valid(mv0),
      .overflow(ov0), .overflow_clr(ovf_clr), .frame_active(fa0)
   );

   cameralink_base_video_stream_rx #(.USE_DVAL(1'b1)) u1 (
      .clk(clk), .rst(rst), .lval(lval), .fval(fval), .dval(dval),
      .port_a(pa), .port_b(pb), .port_c(pc), .m_axis(ax1),
      .line_width(lw1), .frame_height(fh1), .meas_valid(mv1),
      .overflow(ov1), .overflow_clr(ovf_clr), .frame_active(fa1)
   );

   cameralink_base_video_stream_rx #(.FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst(rst), .lval(lval), .fval(fval), .dval(dval),
      .port_a(pa), .port_b(pb), .port_c(pc), .m_axis(ax2),
      .line_width(lw2), .frame_height(fh2), .meas_valid(mv2),
      .overflow(ov2), .overflow_clr(ovf_clr), .frame_active(fa2)
   );

   int n_tests = 0;
   int n_fail = 0;

   // beats as {tuser, tlast, tdata}
   logic [25:0] q0[$];
   logic [25:0] q1[$];
   logic [25:0] q2[$];
   int mvc0 = 0;
   int mvc2 = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (ax0.tvalid && tready) q0.push_back({ax0.tuser, ax0.tlast, ax0.tdata});
         if (ax1.tvalid && tready) q1.push_back({ax1.tuser, ax1.tlast, ax1.tdata});
         if (ax2.tvalid && tready) q2.push_back({ax2.tuser, ax2.tlast, ax2.tdata});
         if (mv0) mvc0++;
         if (mv2) mvc2++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic step(input logic f, input logic l, input logic d,
                       input logic [23:0] px);
      fval = f;
      lval = l;
      dval = d;
      {pc, pb, pa} = px;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 24'd0);
   endtask

   task automatic send_line(input int n, input int base);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 24'(base + i));
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b0, 1'b1, 24'd0);
   endtask

   task automatic send_frame(input int lines, input int ppl, input int base);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      for (int l = 0; l < lines; l++) send_line(ppl, base + l * ppl);
      idle(2);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(3);
   endtask

   task automatic test_reset();
      tready = 1'b1;
      rst = 1'b1;
      idle(3);
      n_tests++;
      if (ax0.tvalid !== 1'b0 || ax0.tdata !== 24'd0) begin
         n_fail++;
         $display("FAIL reset_axis: tvalid=%b tdata=%h want 0", ax0.tvalid, ax0.tdata);
      end
      n_tests++;
      if (lw0 !== 16'd0 || fh0 !== 16'd0 || ov0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_meas: lw=%0d fh=%0d ovf=%b want 0", lw0, fh0, ov0);
      end
      n_tests++;
      if (mv0 !== 1'b0 || fa0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: meas_valid=%b frame_active=%b want 0", mv0, fa0);
      end
      rst = 1'b0;
      idle(3);
   endtask

   task automatic test_basic_frame();
      int s;
      int m;
      logic [25:0] exp;
      logic [25:0] got;
      do_reset();
      tready = 1'b1;
      s = q0.size();
      m = mvc0;
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      send_line(4, 0);
      n_tests++;
      if (fa0 !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_active: frame_active=%b want 1", fa0);
      end
      send_line(4, 4);
      send_line(4, 8);
      idle(8);
      n_tests++;
      if (q0.size() - s != 12) begin
         n_fail++;
         $display("FAIL basic_count: beats=%0d want 12", q0.size() - s);
      end
      for (int i = 0; i < 12; i++) begin
         exp = {(i == 0), (i % 4 == 3), 24'(i)};
         got = (s + i < q0.size()) ? q0[s + i] : 26'hx;
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL basic_beat%0d: got %h want %h", i, got, exp);
         end
      end
      n_tests++;
      if (lw0 !== 16'd4 || fh0 !== 16'd3) begin
         n_fail++;
         $display("FAIL basic_meas: lw=%0d fh=%0d want 4 3", lw0, fh0);
      end
      n_tests++;
      if (mvc0 - m != 1) begin
         n_fail++;
         $display("FAIL basic_meas_valid: pulses=%0d want 1", mvc0 - m);
      end
      n_tests++;
      if (ax0.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drained: tvalid=%b want 0", ax0.tvalid);
      end
   endtask

   task automatic test_midframe_reset();
      int s;
      int m;
      logic [25:0] got;
      tready = 1'b1;
      rst = 1'b1;
      repeat (3) step(1'b1, 1'b0, 1'b1, 24'd0);
      rst = 1'b0;
      s = q0.size();
      m = mvc0;
      send_line(4, 200);
      n_tests++;
      if (fa0 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_active: frame_active=%b want 0", fa0);
      end
      send_line(4, 204);
      idle(3);
      send_frame(1, 4, 100);
      idle(6);
      n_tests++;
      if (q0.size() - s != 4) begin
         n_fail++;
         $display("FAIL midrst_count: beats=%0d want 4", q0.size() - s);
      end
      got = (s < q0.size()) ? q0[s] : 26'hx;
      n_tests++;
      if (got !== {1'b1, 1'b0, 24'd100}) begin
         n_fail++;
         $display("FAIL midrst_first: got %h want %h", got, {1'b1, 1'b0, 24'd100});
      end
      got = (s + 3 < q0.size()) ? q0[s + 3] : 26'hx;
      n_tests++;
      if (got !== {1'b0, 1'b1, 24'd103}) begin
         n_fail++;
         $display("FAIL midrst_last: got %h want %h", got, {1'b0, 1'b1, 24'd103});
      end
      n_tests++;
      if (mvc0 - m != 1 || fh0 !== 16'd1) begin
         n_fail++;
         $display("FAIL midrst_meas: pulses=%0d fh=%0d want 1 1", mvc0 - m, fh0);
      end
   endtask

   task automatic test_dval();
      int s;
      logic [25:0] got;
      do_reset();
      tready = 1'b1;
      s = q1.size();
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b1, 1'b1, 24'd0);
      step(1'b1, 1'b1, 1'b0, 24'd1);
      step(1'b1, 1'b1, 1'b1, 24'd2);
      step(1'b1, 1'b1, 1'b0, 24'd3);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      idle(6);
      n_tests++;
      if (q1.size() - s != 2) begin
         n_fail++;
         $display("FAIL dval_count: beats=%0d want 2", q1.size() - s);
      end
      got = (s < q1.size()) ? q1[s] : 26'hx;
      n_tests++;
      if (got !== {1'b1, 1'b0, 24'd0}) begin
         n_fail++;
         $display("FAIL dval_beat0: got %h want %h", got, {1'b1, 1'b0, 24'd0});
      end
      got = (s + 1 < q1.size()) ? q1[s + 1] : 26'hx;
      n_tests++;
      if (got !== {1'b0, 1'b1, 24'd2}) begin
         n_fail++;
         $display("FAIL dval_beat1: got %h want %h", got, {1'b0, 1'b1, 24'd2});
      end
      n_tests++;
      if (lw1 !== 16'd2 || fh1 !== 16'd1) begin
         n_fail++;
         $display("FAIL dval_meas: lw=%0d fh=%0d want 2 1", lw1, fh1);
      end
   endtask

   task automatic test_overflow();
      int s;
      int m;
      logic [25:0] exp;
      logic [25:0] got;
      do_reset();
      tready = 1'b0;
      s = q2.size();
      m = mvc2;
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      send_line(8, 0);
      n_tests++;
      if (ov2 !== 1'b1 || fa2 !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_set: overflow=%b frame_active=%b want 1 0", ov2, fa2);
      end
      send_line(4, 8);
      idle(3);
      n_tests++;
      if (ax2.tvalid !== 1'b1 || ax2.tdata !== 24'd0 || ax2.tuser !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_hold: tvalid=%b tdata=%h tuser=%b want 1 0 1",
                  ax2.tvalid, ax2.tdata, ax2.tuser);
      end
      n_tests++;
      if (fh2 !== 16'd0 || mvc2 - m != 0) begin
         n_fail++;
         $display("FAIL ovf_nomeas: fh=%0d pulses=%0d want 0 0", fh2, mvc2 - m);
      end
      tready = 1'b1;
      idle(8);
      n_tests++;
      if (q2.size() - s != 4) begin
         n_fail++;
         $display("FAIL ovf_count: beats=%0d want 4", q2.size() - s);
      end
      for (int i = 0; i < 4; i++) begin
         exp = {(i == 0), 1'b0, 24'(i)};
         got = (s + i < q2.size()) ? q2[s + i] : 26'hx;
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL ovf_beat%0d: got %h want %h", i, got, exp);
         end
      end
      n_tests++;
      if (ov2 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: overflow=%b want 1", ov2);
      end
      ovf_clr = 1'b1;
      idle(1);
      ovf_clr = 1'b0;
      n_tests++;
      if (ov2 !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clr: overflow=%b want 0", ov2);
      end
      s = q2.size();
      send_frame(2, 3, 50);
      idle(6);
      n_tests++;
      if (q2.size() - s != 6) begin
         n_fail++;
         $display("FAIL ovf_next_count: beats=%0d want 6", q2.size() - s);
      end
      for (int i = 0; i < 6; i++) begin
         exp = {(i == 0), (i % 3 == 2), 24'(50 + i)};
         got = (s + i < q2.size()) ? q2[s + i] : 26'hx;
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL ovf_next_beat%0d: got %h want %h", i, got, exp);
         end
      end
      n_tests++;
      if (lw2 !== 16'd3 || fh2 !== 16'd2) begin
         n_fail++;
         $display("FAIL ovf_next_meas: lw=%0d fh=%0d want 3 2", lw2, fh2);
      end
   endtask

   task automatic test_one_pixel();
      int s;
      logic [25:0] got;
      do_reset();
      tready = 1'b1;
      s = q0.size();
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b1, 1'b1, 24'hABCDEF);
      idle(6);
      n_tests++;
      if (q0.size() - s != 1) begin
         n_fail++;
         $display("FAIL onepix_count: beats=%0d want 1", q0.size() - s);
      end
      got = (s < q0.size()) ? q0[s] : 26'hx;
      n_tests++;
      if (got !== {1'b1, 1'b1, 24'hABCDEF}) begin
         n_fail++;
         $display("FAIL onepix_beat: got %h want %h", got, {1'b1, 1'b1, 24'hABCDEF});
      end
      n_tests++;
      if (fh0 !== 16'd1 || lw0 !== 16'd1) begin
         n_fail++;
         $display("FAIL onepix_meas: fh=%0d lw=%0d want 1 1", fh0, lw0);
      end
   endtask

   task automatic test_reset_midline();
      do_reset();
      tready = 1'b1;
      send_frame(1, 3, 0);
      idle(4);
      tready = 1'b0;
      step(1'b1, 1'b0, 1'b1, 24'd0);
      step(1'b1, 1'b0, 1'b1, 24'd0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 24'(i));
      n_tests++;
      if (ax2.tvalid !== 1'b1 || ov2 !== 1'b1 || lw2 !== 16'd3 || fh2 !== 16'd1) begin
         n_fail++;
         $display("FAIL rstmid_pre: tvalid=%b ovf=%b lw=%0d fh=%0d want 1 1 3 1",
                  ax2.tvalid, ov2, lw2, fh2);
      end
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b1, 24'd9);
      n_tests++;
      if (ax2.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_tvalid: tvalid=%b want 0", ax2.tvalid);
      end
      n_tests++;
      if (ov2 !== 1'b0 || lw2 !== 16'd0 || fh2 !== 16'd0) begin
         n_fail++;
         $display("FAIL rstmid_meas: ovf=%b lw=%0d fh=%0d want 0 0 0", ov2, lw2, fh2);
      end
      rst = 1'b0;
      tready = 1'b1;
      idle(3);
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_midframe_reset();
      test_dval();
      test_overflow();
      test_one_pixel();
      test_reset_midline();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
